// File: rtl/mod_counter_n.sv
// rtl/mod_counter_n.sv - modulo-N up/down counter with carry/borrow pulses and lap capture
// Cascade stages by feeding carry_out | borrow_out into the next stage's tick.
module mod_counter_n #(
  parameter int MODULUS = 100,
  parameter int WIDTH   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             pause,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             lap,
  input  logic             lap_ack,
  output logic [WIDTH-1:0] cnt_out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err,
  output logic [WIDTH-1:0] lap_out,
  output logic             lap_valid,
  output logic             lap_ovf
);

  generate
    if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_params
      $error("mod_counter_n: MODULUS must be >= 2 and fit in WIDTH bits");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  typedef enum logic {
    LAP_EMPTY = 1'b0,
    LAP_FULL  = 1'b1
  } lap_state_t;

  logic [WIDTH-1:0] r_cnt;
  logic             r_carry;
  logic             r_borrow;
  logic             r_load_err;
  logic [WIDTH-1:0] r_lap_out;
  logic             r_lap_ovf;
  lap_state_t       r_lap_state;

  logic [WIDTH-1:0] w_cnt_next;
  logic             w_carry_next;
  logic             w_borrow_next;
  logic             w_load_err_next;
  logic             w_step;
  lap_state_t       w_lap_state_next;
  logic             w_lap_capture;
  logic             w_lap_ovf_next;

  assign w_step = tick && !pause;

  // Pulses default low so every non-wrapping edge clears them.
  always_comb begin
    w_cnt_next      = r_cnt;
    w_carry_next    = 1'b0;
    w_borrow_next   = 1'b0;
    w_load_err_next = 1'b0;
    if (clr) begin
      w_cnt_next = '0;
    end else if (load) begin
      if (load_val <= LP_MAX) begin
        w_cnt_next = load_val;
      end else begin
        w_cnt_next      = LP_MAX;
        w_load_err_next = 1'b1;
      end
    end else if (w_step) begin
      if (up_dn) begin
        if (r_cnt == LP_MAX) begin
          w_cnt_next   = '0;
          w_carry_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + WIDTH'(1);
        end
      end else begin
        if (r_cnt == '0) begin
          w_cnt_next    = LP_MAX;
          w_borrow_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - WIDTH'(1);
        end
      end
    end
  end

  // A new capture always wins over an ack arriving on the same edge.
  always_comb begin
    w_lap_state_next = r_lap_state;
    w_lap_capture    = 1'b0;
    w_lap_ovf_next   = r_lap_ovf;
    case (r_lap_state)
      LAP_EMPTY: begin
        if (lap) begin
          w_lap_capture    = 1'b1;
          w_lap_state_next = LAP_FULL;
        end
      end
      LAP_FULL: begin
        if (lap) begin
          w_lap_capture = 1'b1;
          if (!lap_ack) begin
            w_lap_ovf_next = 1'b1;
          end
        end else if (lap_ack) begin
          w_lap_state_next = LAP_EMPTY;
        end
      end
      default: w_lap_state_next = LAP_EMPTY;
    endcase
    if (clr) begin
      w_lap_state_next = LAP_EMPTY;
      w_lap_ovf_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_load_err  <= 1'b0;
      r_lap_out   <= '0;
      r_lap_ovf   <= 1'b0;
      r_lap_state <= LAP_EMPTY;
    end else begin
      r_cnt       <= w_cnt_next;
      r_carry     <= w_carry_next;
      r_borrow    <= w_borrow_next;
      r_load_err  <= w_load_err_next;
      r_lap_ovf   <= w_lap_ovf_next;
      r_lap_state <= w_lap_state_next;
      if (w_lap_capture) begin
        r_lap_out <= r_cnt;
      end
    end
  end

  assign cnt_out    = r_cnt;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign load_err   = r_load_err;
  assign lap_out    = r_lap_out;
  assign lap_valid  = (r_lap_state == LAP_FULL);
  assign lap_ovf    = r_lap_ovf;

endmodule

// File: tb/tb_mod_counter_n.sv
// tb/tb_mod_counter_n.sv - self-checking bench for mod_counter_n
// Four moduli share one stimulus set; a separate two-stage chain exercises cascading.
module tb_mod_counter_n;

  localparam int NI = 4;
  localparam int M_MOD [NI] = '{100, 60, 24, 8};
  localparam int M_W   [NI] = '{7, 6, 5, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, pause, up_dn, clr, load, lap, lap_ack;
  logic [6:0] load_val;

  logic [6:0] cnt0, lapo0;
  logic [5:0] cnt1, lapo1;
  logic [4:0] cnt2, lapo2;
  logic [2:0] cnt3, lapo3;
  logic [6:0] d_cnt [NI];
  logic [6:0] d_lapo [NI];
  logic       d_carry [NI];
  logic       d_borrow [NI];
  logic       d_lerr [NI];
  logic       d_valid [NI];
  logic       d_ovf [NI];

  logic       c_tick;
  logic       c_zero = 1'b0;
  logic       c_up = 1'b1;
  logic [6:0] c_lo_cnt, c_lo_lapo;
  logic [5:0] c_hi_cnt, c_hi_lapo;
  logic       c_lo_carry, c_lo_borrow, c_lo_lerr, c_lo_valid, c_lo_ovf;
  logic       c_hi_carry, c_hi_borrow, c_hi_lerr, c_hi_valid, c_hi_ovf;
  logic       c_hi_tick;

  int checks = 0;
  int errors = 0;

  int m_cnt [NI];
  int m_lapo [NI];
  int m_carry [NI];
  int m_borrow [NI];
  int m_lerr [NI];
  int m_valid [NI];
  int m_ovf [NI];

  always #5 clk = ~clk;

  mod_counter_n #(.MODULUS(100), .WIDTH(7)) u_m100 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .lap(lap), .lap_ack(lap_ack), .cnt_out(cnt0), .carry_out(d_carry[0]),
    .borrow_out(d_borrow[0]), .load_err(d_lerr[0]), .lap_out(lapo0), .lap_valid(d_valid[0]), .lap_ovf(d_ovf[0]));
  mod_counter_n #(.MODULUS(60), .WIDTH(6)) u_m60 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[5:0]), .lap(lap), .lap_ack(lap_ack), .cnt_out(cnt1), .carry_out(d_carry[1]),
    .borrow_out(d_borrow[1]), .load_err(d_lerr[1]), .lap_out(lapo1), .lap_valid(d_valid[1]), .lap_ovf(d_ovf[1]));
  mod_counter_n #(.MODULUS(24), .WIDTH(5)) u_m24 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[4:0]), .lap(lap), .lap_ack(lap_ack), .cnt_out(cnt2), .carry_out(d_carry[2]),
    .borrow_out(d_borrow[2]), .load_err(d_lerr[2]), .lap_out(lapo2), .lap_valid(d_valid[2]), .lap_ovf(d_ovf[2]));
  mod_counter_n #(.MODULUS(8), .WIDTH(3)) u_m8 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .lap(lap), .lap_ack(lap_ack), .cnt_out(cnt3), .carry_out(d_carry[3]),
    .borrow_out(d_borrow[3]), .load_err(d_lerr[3]), .lap_out(lapo3), .lap_valid(d_valid[3]), .lap_ovf(d_ovf[3]));

  assign d_cnt[0] = cnt0;
  assign d_cnt[1] = {1'b0, cnt1};
  assign d_cnt[2] = {2'b0, cnt2};
  assign d_cnt[3] = {4'b0, cnt3};
  assign d_lapo[0] = lapo0;
  assign d_lapo[1] = {1'b0, lapo1};
  assign d_lapo[2] = {2'b0, lapo2};
  assign d_lapo[3] = {4'b0, lapo3};

  mod_counter_n #(.MODULUS(100), .WIDTH(7)) u_lo (
    .clk(clk), .rst(rst), .tick(c_tick), .pause(c_zero), .up_dn(c_up), .clr(c_zero), .load(c_zero),
    .load_val(7'd0), .lap(c_zero), .lap_ack(c_zero), .cnt_out(c_lo_cnt), .carry_out(c_lo_carry),
    .borrow_out(c_lo_borrow), .load_err(c_lo_lerr), .lap_out(c_lo_lapo), .lap_valid(c_lo_valid), .lap_ovf(c_lo_ovf));
  assign c_hi_tick = c_lo_carry | c_lo_borrow;
  mod_counter_n #(.MODULUS(60), .WIDTH(6)) u_hi (
    .clk(clk), .rst(rst), .tick(c_hi_tick), .pause(c_zero), .up_dn(c_up), .clr(c_zero), .load(c_zero),
    .load_val(6'd0), .lap(c_zero), .lap_ack(c_zero), .cnt_out(c_hi_cnt), .carry_out(c_hi_carry),
    .borrow_out(c_hi_borrow), .load_err(c_hi_lerr), .lap_out(c_hi_lapo), .lap_valid(c_hi_valid), .lap_ovf(c_hi_ovf));

  function automatic int trunc_lv(input int k);
    return int'(load_val) % (1 << M_W[k]);
  endfunction

  // Reference: counter value as plain modular arithmetic, lap register as a valid flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_cnt[k] <= 0; m_lapo[k] <= 0; m_carry[k] <= 0; m_borrow[k] <= 0;
        m_lerr[k] <= 0; m_valid[k] <= 0; m_ovf[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        m_carry[k]  <= (!clr && !load && tick && !pause && up_dn && m_cnt[k] + 1 == M_MOD[k]) ? 1 : 0;
        m_borrow[k] <= (!clr && !load && tick && !pause && !up_dn && m_cnt[k] == 0) ? 1 : 0;
        m_lerr[k]   <= (!clr && load && trunc_lv(k) >= M_MOD[k]) ? 1 : 0;
        if (clr) m_cnt[k] <= 0;
        else if (load) m_cnt[k] <= (trunc_lv(k) < M_MOD[k]) ? trunc_lv(k) : M_MOD[k] - 1;
        else if (tick && !pause) m_cnt[k] <= up_dn ? (m_cnt[k] + 1) % M_MOD[k] : (m_cnt[k] + M_MOD[k] - 1) % M_MOD[k];
        if (lap) m_lapo[k] <= m_cnt[k];
        if (clr) begin
          m_valid[k] <= 0;
          m_ovf[k]   <= 0;
        end else if (lap) begin
          m_valid[k] <= 1;
          if (m_valid[k] == 1 && !lap_ack) m_ovf[k] <= 1;
        end else if (lap_ack) begin
          m_valid[k] <= 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    tick = 0; pause = 0; up_dn = 1; clr = 0; load = 0; lap = 0; lap_ack = 0; load_val = 7'd0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (d_cnt[k] !== 7'd0 || d_carry[k] !== 1'b0 || d_borrow[k] !== 1'b0 || d_lerr[k] !== 1'b0 ||
          d_lapo[k] !== 7'd0 || d_valid[k] !== 1'b0 || d_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: cnt=%0d c=%b b=%b le=%b lap=%0d v=%b ovf=%b required all 0", k,
                 d_cnt[k], d_carry[k], d_borrow[k], d_lerr[k], d_lapo[k], d_valid[k], d_ovf[k]);
      end
    end
  endtask

  task automatic test_up_wrap();
    idle();
    tick = 1;
    for (int i = 1; i <= 100; i++) begin
      step();
      checks++;
      if (cnt0 !== 7'(i % 100) || d_carry[0] !== (i == 100) || d_borrow[0] !== 1'b0) begin
        errors++;
        $display("FAIL up_wrap tick %0d: cnt=%0d carry=%b borrow=%b required cnt=%0d carry=%b borrow=0",
                 i, cnt0, d_carry[0], d_borrow[0], i % 100, (i == 100));
      end
    end
    tick = 0;
    step();
    checks++;
    if (cnt0 !== 7'd0 || d_carry[0] !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap hold: cnt=%0d carry=%b required 0 0", cnt0, d_carry[0]);
    end
  endtask

  task automatic test_down_pause();
    idle();
    clr = 1;
    step();
    clr = 0; up_dn = 0; tick = 1;
    step();
    checks++;
    if (cnt1 !== 6'd59 || d_borrow[1] !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: cnt=%0d borrow=%b required 59 1", cnt1, d_borrow[1]);
    end
    pause = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cnt1 !== 6'd59 || d_borrow[1] !== 1'b0 || d_carry[1] !== 1'b0) begin
        errors++;
        $display("FAIL pause %0d: cnt=%0d borrow=%b carry=%b required 59 0 0", i, cnt1, d_borrow[1], d_carry[1]);
      end
    end
  endtask

  task automatic test_load();
    idle();
    load = 1; load_val = 7'd17;
    step();
    checks++;
    if (cnt2 !== 5'd17 || d_lerr[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_17: cnt=%0d err=%b required 17 0", cnt2, d_lerr[2]);
    end
    load_val = 7'd30;
    step();
    checks++;
    if (cnt2 !== 5'd23 || d_lerr[2] !== 1'b1) begin
      errors++;
      $display("FAIL load_30: cnt=%0d err=%b required 23 1", cnt2, d_lerr[2]);
    end
    load = 0;
    step();
    checks++;
    if (cnt2 !== 5'd23 || d_lerr[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_err_pulse: cnt=%0d err=%b required 23 0", cnt2, d_lerr[2]);
    end
    load = 1; load_val = 7'd5; tick = 1;
    step();
    checks++;
    if (cnt2 !== 5'd5) begin
      errors++;
      $display("FAIL load_beats_tick: cnt=%0d required 5", cnt2);
    end
    load = 0; up_dn = 0;
    step();
    checks++;
    if (cnt2 !== 5'd4) begin
      errors++;
      $display("FAIL dir_same_edge: cnt=%0d required 4", cnt2);
    end
    clr = 1; load = 1; load_val = 7'd30; up_dn = 1;
    step();
    checks++;
    if (cnt2 !== 5'd0 || d_lerr[2] !== 1'b0 || d_carry[2] !== 1'b0 || d_borrow[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_load_tick: cnt=%0d err=%b c=%b b=%b required 0 0 0 0", cnt2, d_lerr[2], d_carry[2], d_borrow[2]);
    end
  endtask

  task automatic test_lap();
    idle();
    clr = 1;
    step();
    clr = 0; tick = 1;
    repeat (42) step();
    tick = 0; lap = 1;
    step();
    checks++;
    if (lapo0 !== 7'd42 || d_valid[0] !== 1'b1 || d_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL lap_first: lap=%0d valid=%b ovf=%b required 42 1 0", lapo0, d_valid[0], d_ovf[0]);
    end
    lap = 0; tick = 1;
    repeat (8) step();
    tick = 0; lap = 1;
    step();
    checks++;
    if (lapo0 !== 7'd50 || d_valid[0] !== 1'b1 || d_ovf[0] !== 1'b1) begin
      errors++;
      $display("FAIL lap_overwrite: lap=%0d valid=%b ovf=%b required 50 1 1", lapo0, d_valid[0], d_ovf[0]);
    end
    lap = 0; lap_ack = 1;
    step();
    checks++;
    if (lapo0 !== 7'd50 || d_valid[0] !== 1'b0 || d_ovf[0] !== 1'b1) begin
      errors++;
      $display("FAIL lap_ack: lap=%0d valid=%b ovf=%b required 50 0 1", lapo0, d_valid[0], d_ovf[0]);
    end
    lap_ack = 0; clr = 1;
    step();
    checks++;
    if (lapo0 !== 7'd50 || d_ovf[0] !== 1'b0 || cnt0 !== 7'd0) begin
      errors++;
      $display("FAIL lap_clr: lap=%0d ovf=%b cnt=%0d required 50 0 0", lapo0, d_ovf[0], cnt0);
    end
    clr = 0;
  endtask

  task automatic test_async_reset();
    idle();
    clr = 1;
    step();
    clr = 0; tick = 1;
    repeat (37) step();
    tick = 0; lap = 1;
    step();
    lap = 0;
    checks++;
    if (cnt0 !== 7'd37 || d_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d valid=%b required 37 1", cnt0, d_valid[0]);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (cnt0 !== 7'd0 || d_valid[0] !== 1'b0 || lapo0 !== 7'd0 || d_ovf[0] !== 1'b0 ||
        d_carry[0] !== 1'b0 || d_borrow[0] !== 1'b0 || d_lerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d valid=%b lap=%0d ovf=%b required all 0", cnt0, d_valid[0], lapo0, d_ovf[0]);
    end
    @(negedge clk);
    rst = 0;
    tick = 1;
    step();
    checks++;
    if (cnt0 !== 7'd1) begin
      errors++;
      $display("FAIL first_step_after_reset: cnt=%0d required 1", cnt0);
    end
    tick = 0;
  endtask

  task automatic test_cascade();
    int hi_carries;
    hi_carries = 0;
    c_tick = 1;
    repeat (6000) begin
      step();
      if (c_hi_carry === 1'b1) hi_carries++;
    end
    c_tick = 0;
    step();
    if (c_hi_carry === 1'b1) hi_carries++;
    checks++;
    if (c_lo_cnt !== 7'd0 || c_hi_cnt !== 6'd0) begin
      errors++;
      $display("FAIL cascade_zero: lo=%0d hi=%0d required 0 0", c_lo_cnt, c_hi_cnt);
    end
    step();
    if (c_hi_carry === 1'b1) hi_carries++;
    checks++;
    if (hi_carries != 1) begin
      errors++;
      $display("FAIL cascade_carry: pulses=%0d required 1", hi_carries);
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 1500; i++) begin
      tick     = ($urandom % 4) != 0;
      pause    = ($urandom % 8) == 0;
      up_dn    = $urandom % 2;
      clr      = ($urandom % 40) == 0;
      load     = ($urandom % 20) == 0;
      load_val = 7'($urandom % 128);
      lap      = ($urandom % 10) == 0;
      lap_ack  = ($urandom % 4) == 0;
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({25'd0, d_cnt[k]} !== m_cnt[k] || {31'd0, d_carry[k]} !== m_carry[k] ||
            {31'd0, d_borrow[k]} !== m_borrow[k] || {31'd0, d_lerr[k]} !== m_lerr[k] ||
            {25'd0, d_lapo[k]} !== m_lapo[k] || {31'd0, d_valid[k]} !== m_valid[k] ||
            {31'd0, d_ovf[k]} !== m_ovf[k]) begin
          errors++;
          $display("FAIL random[%0d] mod %0d cyc %0d: got cnt=%0d c=%b b=%b le=%b lap=%0d v=%b ovf=%b required %0d %0d %0d %0d %0d %0d %0d",
                   k, M_MOD[k], i, d_cnt[k], d_carry[k], d_borrow[k], d_lerr[k], d_lapo[k], d_valid[k], d_ovf[k],
                   m_cnt[k], m_carry[k], m_borrow[k], m_lerr[k], m_lapo[k], m_valid[k], m_ovf[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    c_tick = 0;
    rst = 1;
    @(negedge clk);
    test_reset();
    rst = 0;
    test_up_wrap();
    test_down_pause();
    test_load();
    test_lap();
    test_async_reset();
    test_cascade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
